// File: rtl/split_initiator_if.sv
// Local request port and serial-bus signals of the split-capable initiator.
// The master modport is the initiator's view; slave is the environment's view
// (local requester, bus arbiter and target together).
interface split_initiator_if;
   logic        req_valid;
   logic        req_rw;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [7:0]  resp_rdata;
   logic        resp_error;
   logic        bus_req;
   logic        bus_grant;
   logic [15:0] init_addr_out;
   logic        init_addr_out_valid;
   logic [7:0]  init_data_out;
   logic        init_data_out_valid;
   logic        init_rw;
   logic [7:0]  init_data_in;
   logic        init_data_in_valid;
   logic        init_ack;
   logic        init_split_ack;
   logic        target_ready;
   logic        split_pending;

   modport master (
      input  req_valid, req_rw, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error,
      output bus_req,
      input  bus_grant,
      output init_addr_out, init_addr_out_valid, init_data_out, init_data_out_valid, init_rw,
      input  init_data_in, init_data_in_valid, init_ack, init_split_ack, target_ready,
      output split_pending
   );

   modport slave (
      output req_valid, req_rw, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error,
      input  bus_req,
      output bus_grant,
      input  init_addr_out, init_addr_out_valid, init_data_out, init_data_out_valid, init_rw,
      output init_data_in, init_data_in_valid, init_ack, init_split_ack, target_ready,
      input  split_pending
   );
endinterface

// File: rtl/split_initiator.sv
// Serial-bus initiator: takes one local read/write at a time, arbitrates for
// the bus, issues address (and write data), then waits for ack or a split
// acknowledge. After a split the bus is released and the deferred read data
// is awaited. Both wait phases are bounded by a saturating timeout counter.
module split_initiator #(
   parameter int ACK_TIMEOUT   = 16,
   parameter int SPLIT_TIMEOUT = 64
) (
   input logic               clk,
   input logic               rst_n,
   split_initiator_if.master bus
);

   localparam int CNT_MAX = (ACK_TIMEOUT > SPLIT_TIMEOUT) ? ACK_TIMEOUT : SPLIT_TIMEOUT;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
   localparam logic [CW-1:0] SPLIT_LAST = CW'(SPLIT_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ_BUS,
      ST_WAIT_ACK,
      ST_SPLIT_WAIT
   } state_t;

   state_t        state;
   logic          lat_rw;
   logic [15:0]   lat_addr;
   logic [7:0]    lat_wdata;
   logic [CW-1:0] cnt;

   // Transaction FSM with all outputs registered; strobes default low each cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                   <= ST_IDLE;
         lat_rw                  <= 1'b0;
         lat_addr                <= '0;
         lat_wdata               <= '0;
         cnt                     <= '0;
         bus.req_ready           <= 1'b1;
         bus.resp_valid          <= 1'b0;
         bus.resp_rdata          <= '0;
         bus.resp_error          <= 1'b0;
         bus.bus_req             <= 1'b0;
         bus.init_addr_out       <= '0;
         bus.init_addr_out_valid <= 1'b0;
         bus.init_data_out       <= '0;
         bus.init_data_out_valid <= 1'b0;
         bus.init_rw             <= 1'b0;
         bus.split_pending       <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; the defaults below are overridden by
         // later assignments in the same pass, which keeps every strobe one cycle wide.
         bus.resp_valid          <= 1'b0;
         bus.init_addr_out_valid <= 1'b0;
         bus.init_data_out_valid <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  lat_rw        <= bus.req_rw;
                  lat_addr      <= bus.req_addr;
                  lat_wdata     <= bus.req_wdata;
                  bus.bus_req   <= 1'b1;
                  bus.req_ready <= 1'b0;
                  state         <= ST_REQ_BUS;
               end
            end

            ST_REQ_BUS: begin
               if (bus.bus_grant && bus.target_ready) begin
                  bus.init_addr_out       <= lat_addr;
                  bus.init_rw             <= lat_rw;
                  bus.init_addr_out_valid <= 1'b1;
                  if (lat_rw) begin
                     bus.init_data_out       <= lat_wdata;
                     bus.init_data_out_valid <= 1'b1;
                  end
                  cnt   <= '0;
                  state <= ST_WAIT_ACK;
               end
            end

            ST_WAIT_ACK: begin
               if (bus.init_ack) begin
                  // A read ack without data is a protocol error.
                  bus.resp_valid    <= 1'b1;
                  bus.resp_error    <= !lat_rw && !bus.init_data_in_valid;
                  bus.resp_rdata    <= (!lat_rw && bus.init_data_in_valid) ? bus.init_data_in : 8'h00;
                  bus.bus_req       <= 1'b0;
                  bus.req_ready     <= 1'b1;
                  state             <= ST_IDLE;
               end else if (bus.init_split_ack && lat_rw) begin
                  // Writes cannot be split.
                  bus.resp_valid    <= 1'b1;
                  bus.resp_error    <= 1'b1;
                  bus.resp_rdata    <= 8'h00;
                  bus.bus_req       <= 1'b0;
                  bus.req_ready     <= 1'b1;
                  state             <= ST_IDLE;
               end else if (bus.init_split_ack) begin
                  bus.bus_req       <= 1'b0;
                  bus.split_pending <= 1'b1;
                  cnt               <= '0;
                  state             <= ST_SPLIT_WAIT;
               end else if (cnt == ACK_LAST) begin
                  bus.resp_valid    <= 1'b1;
                  bus.resp_error    <= 1'b1;
                  bus.resp_rdata    <= 8'h00;
                  bus.bus_req       <= 1'b0;
                  bus.req_ready     <= 1'b1;
                  state             <= ST_IDLE;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end

            ST_SPLIT_WAIT: begin
               if (bus.init_ack && bus.init_data_in_valid) begin
                  bus.resp_valid    <= 1'b1;
                  bus.resp_error    <= 1'b0;
                  bus.resp_rdata    <= bus.init_data_in;
                  bus.split_pending <= 1'b0;
                  bus.req_ready     <= 1'b1;
                  state             <= ST_IDLE;
               end else if (cnt == SPLIT_LAST) begin
                  bus.resp_valid    <= 1'b1;
                  bus.resp_error    <= 1'b1;
                  bus.resp_rdata    <= 8'h00;
                  bus.split_pending <= 1'b0;
                  bus.req_ready     <= 1'b1;
                  state             <= ST_IDLE;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
